and_gate_sync: RTL and testbench
================================

# and_gate_sync

Two-input AND primitive with a combinational output and a clocked monitor path. It is used wherever a plain gated enable is needed and downstream logic also wants a registered copy, edge pulses and an activity count. The combinational path must work with no clock running, so the gate can be exercised standalone.

## Interface

Parameters:
- CNT_W, default 16: width of the high-cycle counter; legal range 2..32.

Ports:
- clk  input  1  system clock; all registered logic is on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all registered outputs immediately.
- A  input  1  gate input A.
- B  input  1  gate input B.
- clr_count  input  1  synchronous clear of hi_count.
- X  output  1  combinational A AND B.
- X_r  output  1  X registered once.
- X_rise  output  1  one-cycle pulse on a 0→1 transition of X_r.
- X_fall  output  1  one-cycle pulse on a 1→0 transition of X_r.
- hi_count  output  CNT_W  saturating count of clock edges at which X_r was 1.

## Operation

- X = A & B, purely combinational.
  - No dependence on clk or rst.
  - Truth table: 00→0, 01→0, 10→0, 11→1.
  - Unknown or undriven inputs propagate per standard AND semantics: any 0 input forces 0.
- Registered path, evaluated on each rising clk edge while rst is low:
  - X_r ← X.
  - X_rise ← X & ~X_r, using the old X_r.
  - X_fall ← ~X & X_r, using the old X_r.
- hi_count, evaluated on each rising edge while rst is low:
  - If clr_count is 1: hi_count ← 0. Clear has priority.
  - Else if the old X_r is 1 and hi_count < 2^CNT_W−1: hi_count ← hi_count + 1.
  - Else: hold. The counter saturates at all-ones and never wraps.
- Reset:
  - While rst is high, X_r, X_rise, X_fall and hi_count are held at 0, regardless of clk.
  - X continues to follow A & B during reset.
  - Reset asserted mid-operation clears the registered outputs asynchronously. Any pulse in progress is cut short.
  - After reset deasserts, the first rising edge samples X normally. If X = 1 at that edge, X_rise pulses, because X_r was 0.

## Timing

- X: zero-cycle latency; combinational delay only.
- X_r: 1-cycle latency from X.
- X_rise and X_fall: asserted in the same cycle X_r changes, for exactly one cycle.
  - They are never both 1.
  - If X toggles faster than clk, only the sampled values matter. Glitches between edges are invisible to the registered path.
- hi_count: reflects X_r with one further cycle of latency.
  - Example: X rises before edge n, X_r = 1 after edge n, and hi_count increments at edge n+1.
- clr_count together with an increment condition at the same edge: result is 0.
- Saturation: at all-ones with X_r = 1, hi_count holds. clr_count still clears it.

## Test plan

- Combinational truth table, no clock toggling: apply AB = 00, 01, 10, 11 at 10-unit spacing. Required X = 0, 0, 0, 1.
- Registered tracking:
  - Stimulus: reset, release, then hold AB = 11 for 3 edges and drop B to 0.
  - Required: X_r = 1 one edge after X rises. X_rise pulses for exactly one cycle aligned with X_r rising. X_fall pulses for one cycle when X_r returns to 0.
  - Required: hi_count = 3 after the fall has propagated.
- Counter clear priority: with X_r = 1 continuously, assert clr_count for one edge. Required: hi_count = 0 after that edge, then 1 after the next edge.
- Saturation: CNT_W = 2, X = 1 held for 6 edges. Required: hi_count reaches 3 and stays at 3.
- Async reset mid-run:
  - Stimulus: with X_r = 1 and hi_count = 5, pulse rst between clock edges.
  - Required: all registered outputs are 0 immediately, without waiting for an edge, and X still equals A & B.
  - Required after release, with AB = 11: X_rise pulses on the first edge.

Source files
------------

// File: rtl/and_gate_sync.sv
// Two-input AND gate with a combinational output plus a registered copy,
// edge pulses and a saturating count of cycles the registered copy was high.
module and_gate_sync #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             clr_count,
    output logic             X,
    output logic             X_r,
    output logic             X_rise,
    output logic             X_fall,
    output logic [CNT_W-1:0] hi_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Kept free of clk/rst so the gate works with no clock running.
    assign X = A & B;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            X_r    <= 1'b0;
            X_rise <= 1'b0;
            X_fall <= 1'b0;
        end else begin
            X_r    <= X;
            X_rise <= X & ~X_r;
            X_fall <= ~X & X_r;
        end
    end

    // Counts on the previous X_r, so it trails X_r by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_count <= '0;
        end else if (clr_count) begin
            hi_count <= '0;
        end else if (X_r && (hi_count != CNT_MAX)) begin
            hi_count <= hi_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_and_gate_sync.sv
// Directed bench for and_gate_sync: truth table, registered tracking,
// clear priority, saturation (CNT_W = 2 instance) and async reset.
module tb_and_gate_sync;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic        A;
    logic        B;
    logic        clr_count;

    logic        X, X_r, X_rise, X_fall;
    logic [15:0] hi_count;
    logic        sX, sX_r, sX_rise, sX_fall;
    logic [1:0]  s_count;

    int checks;
    int failures;

    and_gate_sync #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .clr_count(clr_count),
        .X(X), .X_r(X_r), .X_rise(X_rise), .X_fall(X_fall),
        .hi_count(hi_count)
    );

    and_gate_sync #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .A(A), .B(B), .clr_count(clr_count),
        .X(sX), .X_r(sX_r), .X_rise(sX_rise), .X_fall(sX_fall),
        .hi_count(s_count)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic xr, input logic rise,
                             input logic fall, input logic [15:0] cnt);
        check({tag, ".X_r"}, {31'd0, X_r}, {31'd0, xr});
        check({tag, ".X_rise"}, {31'd0, X_rise}, {31'd0, rise});
        check({tag, ".X_fall"}, {31'd0, X_fall}, {31'd0, fall});
        check({tag, ".hi_count"}, {16'd0, hi_count}, {16'd0, cnt});
    endtask

    initial begin
        logic [1:0] ab;
        logic [3:0] tt_exp;
        checks    = 0;
        failures  = 0;
        clk_en    = 1'b0;
        rst       = 1'b1;
        A         = 1'b0;
        B         = 1'b0;
        clr_count = 1'b0;
        tt_exp    = 4'b1000;
        #1;
        check_reg("reset_state", 1'b0, 1'b0, 1'b0, 16'd0);
        check("reset_state.small_count", {30'd0, s_count}, 32'd0);

        // Truth table with the clock stopped.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            A  = ab[1];
            B  = ab[0];
            #10;
            check($sformatf("truth_%0d%0d", ab[1], ab[0]), {31'd0, X}, {31'd0, tt_exp[i]});
        end

        A = 1'b0;
        B = 1'b0;
        clk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Registered tracking: AB = 11 for three edges, then B drops.
        A = 1'b1;
        B = 1'b1;
        tick();
        check_reg("track_e1", 1'b1, 1'b1, 1'b0, 16'd0);
        tick();
        check_reg("track_e2", 1'b1, 1'b0, 1'b0, 16'd1);
        tick();
        check_reg("track_e3", 1'b1, 1'b0, 1'b0, 16'd2);
        B = 1'b0;
        #1;
        check("track_x_low", {31'd0, X}, 32'd0);
        tick();
        check_reg("track_e4", 1'b0, 1'b0, 1'b1, 16'd3);
        tick();
        check_reg("track_e5", 1'b0, 1'b0, 1'b0, 16'd3);

        // Clear priority while X_r stays high.
        B = 1'b1;
        tick();
        check_reg("clr_rise", 1'b1, 1'b1, 1'b0, 16'd3);
        tick();
        check("clr_pre", {16'd0, hi_count}, 32'd4);
        clr_count = 1'b1;
        tick();
        check("clr_edge", {16'd0, hi_count}, 32'd0);
        clr_count = 1'b0;
        tick();
        check("clr_after", {16'd0, hi_count}, 32'd1);

        // Glitch between edges is not seen by the registered path.
        B = 1'b0;
        #2;
        B = 1'b1;
        tick();
        check_reg("glitch", 1'b1, 1'b0, 1'b0, 16'd2);

        // Fresh start, then saturation on the 2-bit instance.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        check("sat_e1", {30'd0, s_count}, 32'd0);
        tick();
        tick();
        tick();
        check("sat_e4", {30'd0, s_count}, 32'd3);
        tick();
        tick();
        check("sat_e6", {30'd0, s_count}, 32'd3);
        check("sat_e6.big_count", {16'd0, hi_count}, 32'd5);
        check("sat_e6.small_X_r", {31'd0, sX_r}, 32'd1);

        // Async reset pulse between edges with X_r = 1, hi_count = 5.
        #3;
        rst = 1'b1;
        #1;
        check_reg("async_rst", 1'b0, 1'b0, 1'b0, 16'd0);
        check("async_rst.small_count", {30'd0, s_count}, 32'd0);
        check("async_rst.X", {31'd0, X}, 32'd1);
        A = 1'b0;
        #1;
        check("async_rst.X_follow", {31'd0, X}, 32'd0);
        A = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        check_reg("post_rst_e1", 1'b1, 1'b1, 1'b0, 16'd0);
        check("post_rst_e1.small_rise", {31'd0, sX_rise}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
